// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared request encodings and request bundle type for the two-port memory arbiter
package mem_arb_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic REQ_IMEM  = 1'b0;
  localparam logic REQ_DMEM  = 1'b1;

  // Widest bus the bundle can carry; narrower instances zero-extend into it.
  localparam int MAX_ADDR_W = 64;
  localparam int MAX_DATA_W = 64;

  typedef struct packed {
    logic                  val;
    logic                  req_type;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_picker2.sv
// rtl/rr_picker2.sv - combinational two-way round-robin grant selection with transaction lock
module rr_picker2
  import mem_arb_pkg::*;
(
  input  logic val0,
  input  logic val1,
  input  logic last_id,
  input  logic lock,
  input  logic lock_id,
  output logic gnt_val,
  output logic gnt_id
);

  always_comb begin
    gnt_val = 1'b0;
    gnt_id  = REQ_IMEM;
    if (lock) begin
      // A locked grantee that drops val yields no grant rather than handing over mid-cycle.
      gnt_id  = lock_id;
      gnt_val = lock_id ? val1 : val0;
    end else if (val0 && val1) begin
      gnt_val = 1'b1;
      gnt_id  = ~last_id;
    end else if (val0) begin
      gnt_val = 1'b1;
      gnt_id  = REQ_IMEM;
    end else if (val1) begin
      gnt_val = 1'b1;
      gnt_id  = REQ_DMEM;
    end
  end

endmodule

// File: rtl/mem_arbiter_rr2.sv
// rtl/mem_arbiter_rr2.sv - round-robin sharing of one memory port between imem/dmem requesters (optional MEM_ARBITER_PERF_EN counters)
module mem_arbiter_rr2
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIRST_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_val,
  output logic              req0_wait,
  input  logic              req0_type,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_val,
  output logic              req1_wait,
  input  logic              req1_type,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_val,
  input  logic              mem_wait,
  output logic              mem_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_conflict
`endif
);

  localparam logic FIRST_ID = (FIRST_PRIO != 0);

  logic     lock, lock_id, last_id;
  logic     pick_val, gnt_id, gnt;
  logic     sel0, sel1;
  mem_req_t r0, r1, rg;

  rr_picker2 u_picker (
    .val0    (req0_val),
    .val1    (req1_val),
    .last_id (last_id),
    .lock    (lock),
    .lock_id (lock_id),
    .gnt_val (pick_val),
    .gnt_id  (gnt_id)
  );

  // Holding rst forces the idle bus even while requesters keep val high.
  assign gnt  = pick_val & ~rst;
  assign sel0 = gnt & (gnt_id == REQ_IMEM);
  assign sel1 = gnt & (gnt_id == REQ_DMEM);

  assign r0 = '{val: req0_val, req_type: req0_type,
                addr: MAX_ADDR_W'(req0_addr), wdata: MAX_DATA_W'(req0_wdata)};
  assign r1 = '{val: req1_val, req_type: req1_type,
                addr: MAX_ADDR_W'(req1_addr), wdata: MAX_DATA_W'(req1_wdata)};
  assign rg = sel1 ? r1 : r0;

  assign mem_val    = gnt & rg.val;
  assign mem_type   = rg.req_type;
  assign mem_addr   = ADDR_W'(rg.addr);
  assign mem_wdata  = DATA_W'(rg.wdata);
  assign req0_rdata = mem_rdata;
  assign req1_rdata = mem_rdata;

  assign req0_wait = req0_val & (sel0 ? mem_wait : 1'b1);
  assign req1_wait = req1_val & (sel1 ? mem_wait : 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock    <= 1'b0;
      lock_id <= REQ_IMEM;
      last_id <= ~FIRST_ID;
    end else if (gnt) begin
      if (mem_wait) begin
        lock    <= 1'b1;
        lock_id <= gnt_id;
      end else begin
        lock    <= 1'b0;
        last_id <= gnt_id;
      end
    end else if (lock) begin
      lock <= 1'b0;
    end
  end

`ifdef MEM_ARBITER_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grant0   <= 32'd0;
      perf_grant1   <= 32'd0;
      perf_conflict <= 32'd0;
    end else begin
      if (sel0 && !mem_wait) perf_grant0 <= sat_inc32(perf_grant0);
      if (sel1 && !mem_wait) perf_grant1 <= sat_inc32(perf_grant1);
      if (req0_val && req1_val) perf_conflict <= sat_inc32(perf_conflict);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter_rr2.sv
// tb/tb_mem_arbiter_rr2.sv - directed scoreboard bench for mem_arbiter_rr2
module tb_mem_arbiter_rr2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_val, req0_wait, req0_type;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_val, req1_wait, req1_type;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic        mem_val, mem_wait, mem_type;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  always #5 clk = ~clk;

  mem_arbiter_rr2 #(.ADDR_W(32), .DATA_W(32), .FIRST_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req0_val(req0_val), .req0_wait(req0_wait), .req0_type(req0_type),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_rdata(req0_rdata),
    .req1_val(req1_val), .req1_wait(req1_wait), .req1_type(req1_type),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_rdata(req1_rdata),
    .mem_val(mem_val), .mem_wait(mem_wait), .mem_type(mem_type),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARBITER_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
`endif
  );

  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic [31:0] rdata;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  localparam logic [31:0] A0 = 32'h0000_0200;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] D1 = 32'hdead_beef;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from the negedge, check combinational outputs, then advance to the next negedge.
  task automatic cyc(input logic v0, input logic v1, input logic t1, input logic mw,
                     input logic ev, input logic eid, input logic ew0, input logic ew1);
    sb_t         e;
    sb_t         got;
    logic [31:0] rd;
    logic        obs_id;
    req0_val = v0; req0_type = 1'b0; req0_addr = A0; req0_wdata = 32'h0;
    req1_val = v1; req1_type = t1;   req1_addr = A1; req1_wdata = D1;
    mem_wait = mw;
    rd = $urandom;
    mem_rdata = rd;
    if (ev && !mw) begin
      e.id = eid; e.addr = eid ? A1 : A0; e.rdata = rd;
      sb.push_back(e);
    end
    #2;
    check("mem_val", {63'd0, mem_val}, {63'd0, ev});
    check("req0_wait", {63'd0, req0_wait}, {63'd0, ew0});
    check("req1_wait", {63'd0, req1_wait}, {63'd0, ew1});
    if (ev) begin
      check("mem_addr", {32'd0, mem_addr}, {32'd0, (eid ? A1 : A0)});
      check("mem_type", {63'd0, mem_type}, {63'd0, (eid ? t1 : 1'b0)});
      if (eid) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, D1});
    end
    if (mem_val && !mem_wait) begin
      check("sb_has_entry", {63'd0, (sb.size() != 0)}, 64'd1);
      if (sb.size() != 0) begin
        got = sb.pop_front();
        obs_id = req1_val && !req1_wait;
        check("cmpl_id", {63'd0, obs_id}, {63'd0, got.id});
        check("cmpl_addr", {32'd0, mem_addr}, {32'd0, got.addr});
        check("cmpl_rdata", {32'd0, (got.id ? req1_rdata : req0_rdata)}, {32'd0, got.rdata});
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_val = 1'b0; req1_val = 1'b0; mem_wait = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_val", {63'd0, mem_val}, 64'd0);
    check("rst_req0_wait", {63'd0, req0_wait}, 64'd0);
    check("rst_req1_wait", {63'd0, req1_wait}, 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_val = 1'b0; req0_type = 1'b0; req0_addr = 32'h0; req0_wdata = 32'h0;
    req1_val = 1'b0; req1_type = 1'b0; req1_addr = 32'h0; req1_wdata = 32'h0;
    mem_wait = 1'b0; mem_rdata = 32'h0;
    do_reset();

    // Lone read passes through; following tie must favour req1 since last_id is now 0.
    cyc(1, 0, 0, 0,  1, 0, 0, 0);
    cyc(1, 1, 1, 0,  1, 1, 1, 0);

    // First tie after reset goes to req0, then req1 with its write.
    do_reset();
    cyc(1, 1, 1, 0,  1, 0, 0, 1);
    cyc(1, 1, 1, 0,  1, 1, 1, 0);

    // Six cycles of steady contention alternate 0,1,0,1,0,1.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) cyc(1, 1, 0, 0,  1, 0, 0, 1);
      else            cyc(1, 1, 0, 0,  1, 1, 1, 0);
    end
`ifdef MEM_ARBITER_PERF_EN
    check("perf_grant0", {32'd0, perf_grant0}, 64'd3);
    check("perf_grant1", {32'd0, perf_grant1}, 64'd3);
    check("perf_conflict", {32'd0, perf_conflict}, 64'd6);
`endif

    // req1 locked through three wait cycles; req0 arrives with priority but stays blocked.
    cyc(0, 1, 0, 1,  1, 1, 0, 1);
    cyc(1, 1, 0, 1,  1, 1, 1, 1);
    cyc(1, 1, 0, 1,  1, 1, 1, 1);
    cyc(1, 1, 0, 0,  1, 1, 1, 0);
    cyc(1, 0, 0, 0,  1, 0, 0, 0);

    // Reset mid-lock idles the bus at once; the next tie goes to FIRST_PRIO.
    cyc(0, 1, 0, 1,  1, 1, 0, 1);
    rst = 1'b1;
    #1;
    check("rst_async_mem_val", {63'd0, mem_val}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 1, 0, 0,  1, 0, 0, 1);

    // Locked grantee drops val: no grant that cycle, lock released for the next.
    cyc(0, 1, 0, 1,  1, 1, 0, 1);
    cyc(1, 0, 0, 1,  0, 0, 1, 0);
    cyc(1, 0, 0, 0,  1, 0, 0, 0);

    check("sb_drained", {32'd0, sb.size()}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr2.md
Name: mem_arbiter_rr2

Overview:
- Shares one single-ported memory between the processor's instruction port (req0) and data port (req1), so ProcScycle can run against a one-port memory.
- Uses the same val/wait/type/addr/wdata/rdata protocol on both sides and sits between the processor and the memory.
- Uncontended requests pass through combinationally with zero added latency.
- Contended requests are served round-robin, and a grant is held for the whole multi-cycle memory transaction.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- FIRST_PRIO, 0, requester that wins the first tie after reset (0 or 1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req0_val  in  1  requester 0 request valid
- req0_wait  out  1  requester 0 must hold its request
- req0_type  in  1  0=read, 1=write
- req0_addr  in  ADDR_W  address
- req0_wdata  in  DATA_W  write data
- req0_rdata  out  DATA_W  read data
- req1_val, req1_wait, req1_type, req1_addr, req1_wdata, req1_rdata  same directions and widths as req0
- mem_val  out  1  downstream request valid
- mem_wait  in  1  downstream not finished
- mem_type  out  1  downstream type
- mem_addr  out  ADDR_W  downstream address
- mem_wdata  out  DATA_W  downstream write data
- mem_rdata  in  DATA_W  downstream read data

Behaviour:
- Protocol:
  - A transaction completes in a cycle where val=1 and wait=0.
  - rdata is valid in the completion cycle only.
  - A requester seeing wait=1 holds val/type/addr/wdata stable.
- State:
  - lock (1b), lock_id (1b), last_id (1b).
  - Reset: lock=0, lock_id=0, last_id=~FIRST_PRIO.
- Grant selection when lock=0 (combinational):
  - Only one val high: grant that requester.
  - Both high: grant ~last_id.
  - Neither high: no grant.
- When lock=1: the grant is lock_id, regardless of the other requester.
- Datapath outputs:
  - mem_val = granted requester's val.
  - mem_type/addr/wdata are muxed from the grantee.
  - With no grant: mem_val=0; mem_type/addr/wdata are driven from req0 (don't-care, no X).
  - mem_rdata is fanned out to both reqN_rdata.
- Wait outputs:
  - Grantee: reqN_wait = mem_wait.
  - Non-grantee with val=1: reqN_wait = 1.
  - Requester with val=0: reqN_wait = 0.
- State updates on clk rising edge:
  - Grant present and mem_wait=1: lock<=1, lock_id<=grant.
  - Grant present and mem_wait=0 (completion): lock<=0, last_id<=grant.
  - Locked grantee drops val (protocol violation): lock<=0, last_id unchanged, no stall propagated.
- Latency:
  - Uncontended, zero-wait access: 0 cycles, completes in the same cycle.
  - Contended loser: stalled for the full duration of the winner's transaction plus 0 cycles.
  - Back-to-back alternation: each requester gets at most every other completion when both stay valid.
- Boundaries:
  - Simultaneous completion and new contention: the new tie uses the updated last_id on the next cycle.
  - A requester newly raising val while the other is locked is blocked even if it has priority.
  - rst asserted mid-transaction: lock clears immediately (async), outputs fall to the no-grant values above, and in-flight requests are reissued by requesters after reset.

Optional Feature:
- Macro MEM_ARBITER_PERF_EN.
- Defined: adds outputs perf_grant0, perf_grant1, perf_conflict (32b each), reset to 0 asynchronously.
  - perf_grantN increments on each completion for requester N.
  - perf_conflict increments on each cycle where both val are high.
  - All counters saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg:
  - MEM_READ=1'b0, MEM_WRITE=1'b1.
  - REQ_IMEM=1'b0, REQ_DMEM=1'b1.
  - Typedef mem_req_t {val, type, addr, wdata}.
- One sub-module rr_picker2:
  - Inputs val0, val1, last_id, lock, lock_id.
  - Outputs gnt_val, gnt_id.
  - Purely combinational; all flops stay in mem_arbiter_rr2.

Test Plan:
- req0 read addr 0x200, no req1, mem_wait=0 -> same cycle: mem_val=1, mem_addr=0x200, req0_rdata=mem_rdata, req0_wait=0, last_id becomes 0.
- Both valid after reset (req0 read 0x200, req1 write 0x2000 data 0xdeadbeef), mem_wait=0 -> cycle 1 grants req0 with req1_wait=1; cycle 2 grants req1 with mem_type=1 and mem_wdata=0xdeadbeef.
- Both held valid for 6 cycles with mem_wait=0 -> grants alternate 0,1,0,1,0,1.
- req1 granted, mem_wait=1 for 3 cycles; req0 raises val in cycle 2 -> req1 stays granted until completion in cycle 4, req0_wait=1 throughout, req0 granted in cycle 5.
- rst pulsed mid-lock (req1 locked, mem_wait=1) -> immediate mem_val=0 and lock=0; first tie after rst release goes to FIRST_PRIO.
- With MEM_ARBITER_PERF_EN, run the alternating scenario for 6 cycles -> perf_grant0=3, perf_grant1=3, perf_conflict=6.
